mul_div_seq: RTL and testbench
==============================

# mul_div_seq

Sequential signed multiply/divide unit for the Mini SRC datapath. It sits beside the combinational ALU, which delegates opcodes MUL and DIV to it. It consumes the same RA/RB operands and produces the 64-bit RZ word that is latched into ZHigh/ZLow and then into HI/LO. Each operation iterates one bit per clock, so the control unit holds the datapath until `done`.

## Interface
- `WIDTH`, default 32: operand width. The result is 2*WIDTH. Only 32 is verified.
- `clock`, in, 1: rising-edge clock.
- `clear`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: request. Sampled only when idle.
- `opcode`, in, 5: 5'b01111 = MUL, 5'b10000 = DIV. Any other value is ignored.
- `RA`, in, 32: multiplicand or dividend, two's complement.
- `RB`, in, 32: multiplier or divisor, two's complement.
- `busy`, out, 1: high from the cycle after an accepted start until `done`, inclusive.
- `done`, out, 1: one-cycle pulse. RZ is valid in that cycle.
- `div_by_zero`, out, 1: valid with `done`. Holds until the next accepted start.
- `RZ`, out, 64: result.
  - MUL: the full signed product.
  - DIV: {remainder, quotient}. RZ[63:32] goes to HI, RZ[31:0] goes to LO.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1 with a legal opcode, the unit does the following at the same edge, then goes to RUN.
  - Latches the operands and the operation.
  - Clears the iteration counter to 0.
- Starts that are ignored:
  - start in any state other than IDLE.
  - start with an illegal opcode. The unit stays in IDLE and no `done` is produced.
- MUL uses radix-2 Booth recoding on a 65-bit {A, Q, q-1} register.
  - Each RUN cycle adds +M, -M or 0 per the {Q[0], q-1} pair, then arithmetic-shifts right by 1.
  - After 32 iterations: RUN to DONE.
  - RZ = {A, Q}.
- DIV uses restoring division on the magnitudes |RA| and |RB|.
  - Each RUN cycle shifts the {R, Q} register left by one.
  - It then subtracts |RB|. If the result is non-negative, it keeps the result and sets Q[0]=1. Otherwise it restores.
  - After 32 iterations: RUN to FIX.
- FIX (DIV only) applies the sign rules, then goes to DONE.
  - Quotient is negated when sign(RA) XOR sign(RB). Truncation is toward zero.
  - Remainder takes the sign of RA.
- Divide by zero: DIV with RB=0 goes IDLE to DONE directly, skipping RUN and FIX.
  - RZ = {RA, 32'hFFFF_FFFF}.
  - div_by_zero = 1.
- Overflow: DIV of -2^31 by -1 wraps. RZ = {32'h0, 32'h8000_0000}. div_by_zero = 0.
- DONE: done=1 for exactly one cycle, then IDLE.
- RZ and div_by_zero hold their values until the next accepted start.
- RZ is not guaranteed while busy. The control unit must not capture it before `done`.
- Reset values (clear asserted, any state): state IDLE, RZ=0, busy=0, done=0, div_by_zero=0, counter=0.
  - clear mid-operation aborts the operation with no `done` pulse.

## Timing
- Accept edge = edge 0.
- MUL: RUN occupies edges 1..32. done is high during the cycle after edge 33.
- DIV: RUN occupies edges 1..32, then FIX, then DONE. done is high after edge 34.
- Divide by zero: done is high after edge 1.
- Back-to-back operation: start asserted in the same cycle as `done` is ignored. The earliest new accept is the cycle after `done`, when the unit is back in IDLE.
- busy is registered. It rises after edge 0 and falls with `done` deasserting.
- Iteration counter: 6 bits. Terminal count 31 is checked in RUN.
- All arithmetic is 33-bit signed internally so that -M of -2^31 does not overflow.

## Structure
- Shared package `cpu_defs`:
  - opcode constants OP_MUL = 5'b01111 and OP_DIV = 5'b10000
  - state encoding for this FSM
- Sub-module `booth_step`, combinational:
  - inputs: A, Q, q-1, M
  - outputs: the next A, Q, q-1 after add/sub and arithmetic shift
  - It is reused by the multiply path only.
- The divide step, sign fix-up and FSM are inline in `mul_div_seq`.

## Test plan
- MUL RA=7, RB=-3 -> after 33 cycles: done=1, RZ=64'hFFFF_FFFF_FFFF_FFEB, busy low the next cycle.
- MUL RA=RB=32'h8000_0000 -> RZ=64'h4000_0000_0000_0000. MUL RA=-1, RB=-1 -> RZ=64'h1.
- DIV RA=-17, RB=5 -> after 34 cycles: RZ={32'hFFFF_FFFE, 32'hFFFF_FFFD} (rem -2, quot -3). DIV RA=17, RB=-5 -> rem 2, quot -3.
- DIV RA=9, RB=0 -> done after 1 cycle, div_by_zero=1, RZ={32'h9, 32'hFFFF_FFFF}. DIV of 32'h8000_0000 by -1 -> RZ={0, 32'h8000_0000}.
- start pulsed during RUN with different operands -> ignored, original result returned. start with opcode 5'b00011 in IDLE -> no busy, no done.
- clear asserted at RUN iteration 10 -> outputs zero immediately, no done. A fresh MUL afterwards completes correctly.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared Mini SRC definitions: ALU-delegated opcodes and the mul/div FSM encoding.
package cpu_defs;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam int         CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on {A, Q, q-1}: add +M/-M/0, then arithmetic shift right by one.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        // One guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
        a_ext = {a_i[WIDTH-1], a_i};
        m_ext = {m_i[WIDTH-1], m_i};
        unique case ({q_i[0], qm1_i})
            2'b10:   sum = a_ext - m_ext;
            2'b01:   sum = a_ext + m_ext;
            default: sum = a_ext;
        endcase
        a_o   = sum[WIDTH:1];
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        qm1_o = q_i[0];
    end
endmodule

// File: rtl/mul_div_seq.sv
// Sequential signed multiply (Booth) / divide (restoring) unit, one bit per clock.
// Result is RZ = product, or {remainder, quotient} for DIV.
module mul_div_seq
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   RA,
    input  logic [WIDTH-1:0]   RB,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] RZ
);
    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] rz_q, rz_d;

    logic [WIDTH-1:0]   b_a, b_q;
    logic               b_qm1;
    logic [WIDTH:0]     r_sh, diff;
    logic [WIDTH-1:0]   ra_abs, rb_abs;
    logic               accept;

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .a_i   (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (b_a),
        .q_o   (b_q),
        .qm1_o (b_qm1)
    );

    always_comb begin
        ra_abs = RA[WIDTH-1] ? -RA : RA;
        rb_abs = RB[WIDTH-1] ? -RB : RB;
        r_sh   = {1'b0, acc_q, q_q[WIDTH-1]};
        diff   = r_sh - {1'b0, m_q};
        // The done cycle is already IDLE; blocking it makes the cycle after done the earliest accept.
        accept = start && (state_q == ST_IDLE) && !done_q && is_md_op(opcode);

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        busy_d  = done_q ? 1'b0 : busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        rz_d    = rz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    dbz_d  = 1'b0;
                    qm1_d  = 1'b0;
                    div_d  = (opcode == OP_DIV);
                    negq_d = RA[WIDTH-1] ^ RB[WIDTH-1];
                    negr_d = RA[WIDTH-1];
                    if (opcode == OP_DIV) begin
                        if (RB == '0) begin
                            acc_d   = RA;
                            q_d     = '1;
                            dbz_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            acc_d   = '0;
                            q_d     = ra_abs;
                            m_d     = rb_abs;
                            state_d = ST_RUN;
                        end
                    end else begin
                        acc_d   = '0;
                        q_d     = RB;
                        m_d     = RA;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = r_sh[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = b_a;
                    q_d   = b_q;
                    qm1_d = b_qm1;
                end
                if (cnt_q == CNT_W'(WIDTH-1))
                    state_d = div_q ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                q_d     = negq_q ? -q_q : q_q;
                acc_d   = negr_q ? -acc_q : acc_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                rz_d    = {acc_q, q_q};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            rz_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            rz_q    <= rz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign RZ          = rz_q;
endmodule

// File: tb/tb_mul_div_seq.sv
// Directed vector bench for mul_div_seq: result table plus hand-written corner sequences.
module tb_mul_div_seq;
    localparam logic [4:0] MUL = 5'b01111;
    localparam logic [4:0] DIV = 5'b10000;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [31:0] RA = '0;
    logic [31:0] RB = '0;
    logic        busy, done, div_by_zero;
    logic [63:0] RZ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rz;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    mul_div_seq dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .RA          (RA),
        .RB          (RB),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .RZ          (RZ)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Issue one op, optionally poking a different start at cycle poke_at, and check the result.
    task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [63:0] exp_rz,
                          input logic exp_dbz, input int exp_lat, input int poke_at);
        int lat;
        @(negedge clock);
        opcode = op; RA = ra; RB = rb; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = c;
                break;
            end
            if (c == poke_at) begin
                opcode = DIV; RA = 32'd100; RB = 32'd7; start = 1'b1;
            end else if (c == poke_at + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        if (lat != 0) begin
            chk({nm, " RZ"}, RZ, exp_rz);
            chk({nm, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
            chk({nm, " busy@done"}, 64'(busy), 64'd1);
            @(posedge clock); #1;
            chk({nm, " busy after"}, 64'(busy), 64'd0);
            chk({nm, " done 1-cycle"}, 64'(done), 64'd0);
            chk({nm, " RZ hold"}, RZ, exp_rz);
        end
    endtask

    initial begin
        int seen;
        vecs[0]  = '{"mul 7*-3",      MUL, 32'd7,          -32'sd3,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33};
        vecs[1]  = '{"mul min*min",   MUL, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0, 33};
        vecs[2]  = '{"mul -1*-1",     MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 1'b0, 33};
        vecs[3]  = '{"mul max*max",   MUL, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001, 1'b0, 33};
        vecs[4]  = '{"mul min*max",   MUL, 32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000, 1'b0, 33};
        vecs[5]  = '{"mul 0x1234*16", MUL, 32'h1234,       32'h10,         64'h0000_0000_0001_2340, 1'b0, 33};
        vecs[6]  = '{"div -17/5",     DIV, -32'sd17,       32'd5,          {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 1'b0, 34};
        vecs[7]  = '{"div 17/-5",     DIV, 32'd17,         -32'sd5,        {32'h0000_0002, 32'hFFFF_FFFD}, 1'b0, 34};
        vecs[8]  = '{"div -17/-5",    DIV, -32'sd17,       -32'sd5,        {32'hFFFF_FFFE, 32'h0000_0003}, 1'b0, 34};
        vecs[9]  = '{"div 100/7",     DIV, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 1'b0, 34};
        vecs[10] = '{"div min/-1",    DIV, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 1'b0, 34};
        vecs[11] = '{"div min/min",   DIV, 32'h8000_0000,  32'h8000_0000,  {32'h0000_0000, 32'h0000_0001}, 1'b0, 34};
        vecs[12] = '{"div 9/0",       DIV, 32'd9,          32'd0,          {32'h0000_0009, 32'hFFFF_FFFF}, 1'b1, 1};
        vecs[13] = '{"div -7/0",      DIV, -32'sd7,        32'd0,          {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1, 1};

        #12;
        chk("reset RZ", RZ, 64'd0);
        chk("reset busy/done/dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock);
        clear = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rz,
                   vecs[i].dbz, vecs[i].lat, 0);

        // dbz from the last vector must persist until the next accepted start
        chk("dbz hold", 64'(div_by_zero), 64'd1);

        // clear during RUN iteration 10: outputs drop at once, no done follows
        @(negedge clock);
        opcode = MUL; RA = 32'd7; RB = -32'sd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 clear = 1'b1;
        #1;
        chk("clear RZ", RZ, 64'd0);
        chk("clear busy/done/dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) seen++;
        end
        chk("no done after clear", 64'(seen), 64'd0);
        run_op("mul after clear", MUL, 32'h8000_0000, 32'h7FFF_FFFF,
               64'hC000_0000_8000_0000, 1'b0, 33, 0);

        // start poked mid-RUN with other operands is ignored
        run_op("mul poke in RUN", MUL, 32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33, 5);

        // illegal opcode in IDLE: never busy, never done
        @(negedge clock);
        opcode = 5'b00011; RA = 32'd5; RB = 32'd6; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) seen++;
        end
        chk("illegal opcode ignored", 64'(seen), 64'd0);

        // start held through done: ignored during done, accepted the cycle after
        @(negedge clock);
        opcode = DIV; RA = 32'd9; RB = 32'd0; start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("b2b done", 64'(done), 64'd1);
        @(posedge clock); #1;
        chk("b2b start in done ignored", 64'(busy), 64'd0);
        @(posedge clock); #1;
        chk("b2b accept after done", 64'(busy), 64'd1);
        start = 1'b0;
        @(posedge clock); #1;
        chk("b2b second done", 64'(done), 64'd1);
        chk("b2b second RZ", RZ, {32'h0000_0009, 32'hFFFF_FFFF});
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
